// File: rtl/formula_loader.sv
// formula_loader: assembles a serial literal stream into a packed SAT formula with valid/ready on both sides.
package common;
    localparam int number_clauses = 10;
    localparam int number_literal = 5;
    localparam int LIT_W = $clog2(number_literal + 1);
    localparam int CL_W = $clog2(number_clauses + 1);
    typedef struct packed {
        logic [LIT_W-1:0] num;
        logic             val;
    } literal;
    typedef struct packed {
        logic [LIT_W-1:0]                len;
        literal [number_literal-1:0]     lits;
    } clause;
    typedef struct packed {
        logic [CL_W-1:0]                 len;
        clause [number_clauses-1:0]      clauses;
    } formula;
endpackage

module formula_loader #(
    parameter int NUM_CLAUSES = common::number_clauses,
    parameter int NUM_LITERALS = common::number_literal,
    localparam int LW = $clog2(NUM_LITERALS + 1),
    localparam int CW = $clog2(NUM_CLAUSES + 1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [LW-1:0]  in_num,
    input  logic           in_val,
    input  logic           in_eoc,
    input  logic           in_eof,
    output common::formula out_formula,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           err,
    output logic [1:0]     err_code
);
    typedef enum logic [1:0] {COLLECT, DONE, ERR} state_t;

    state_t         state, state_n;
    common::formula f, f_n;
    logic [LW-1:0]  lit_idx, lit_n;
    logic [CW-1:0]  clause_idx, clause_n;
    logic           err_n, accept, last;
    logic [1:0]     code_n, bad;

    assign in_ready = state != DONE;
    assign out_valid = state == DONE;
    assign out_formula = f;
    assign accept = in_valid && in_ready;
    assign last = in_eoc || in_eof;
    assign bad = (in_num == '0 || in_num > LW'(NUM_LITERALS)) ? 2'd1 :
                 (lit_idx == LW'(NUM_LITERALS))                ? 2'd2 :
                 (clause_idx == CW'(NUM_CLAUSES))              ? 2'd3 : 2'd0;

    always_comb begin
        state_n = state;
        f_n = f;
        lit_n = lit_idx;
        clause_n = clause_idx;
        err_n = 1'b0;
        code_n = 2'd0;
        if (state == COLLECT && accept) begin
            if (bad != 2'd0) begin
                // an erroring eof beat both flags and closes the stream, so err only pulses
                err_n = 1'b1;
                code_n = bad;
                if (in_eof) begin
                    f_n = '0;
                    lit_n = '0;
                    clause_n = '0;
                end else begin
                    state_n = ERR;
                end
            end else begin
                f_n.clauses[clause_idx].lits[lit_idx] = {in_num, in_val};
                f_n.clauses[clause_idx].len = lit_idx + LW'(1);
                f_n.len = clause_idx + CW'(1);
                lit_n = last ? '0 : lit_idx + LW'(1);
                clause_n = last ? clause_idx + CW'(1) : clause_idx;
                state_n = in_eof ? DONE : COLLECT;
            end
        end else if (state == DONE && out_ready) begin
            state_n = COLLECT;
            f_n = '0;
            lit_n = '0;
            clause_n = '0;
        end else if (state == ERR) begin
            err_n = !(accept && in_eof);
            code_n = (accept && in_eof) ? 2'd0 : err_code;
            if (accept && in_eof) begin
                state_n = COLLECT;
                f_n = '0;
                lit_n = '0;
                clause_n = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= COLLECT;
            f <= '0;
            lit_idx <= '0;
            clause_idx <= '0;
            err <= 1'b0;
            err_code <= 2'd0;
        end else begin
            state <= state_n;
            f <= f_n;
            lit_idx <= lit_n;
            clause_idx <= clause_n;
            err <= err_n;
            err_code <= code_n;
        end
    end
endmodule

// File: tb/tb_formula_loader.sv
// tb_formula_loader: clause-queue reference model checked every cycle, plus directed hand-computed checks.
module tb_formula_loader;
    localparam int NC = common::number_clauses;
    localparam int NL = common::number_literal;
    localparam int LW = common::LIT_W;
    localparam int CW = common::CL_W;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [LW-1:0]  in_num = '0;
    logic           in_val = 1'b0;
    logic           in_eoc = 1'b0;
    logic           in_eof = 1'b0;
    common::formula out_formula;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic           err;
    logic [1:0]     err_code;

    int checks = 0;
    int failures = 0;

    // model: each clause is a queue of literals encoded num*2+val; mode 0 collect, 1 done, 2 error-drain
    int cls[NC][$];
    int nclosed = 0;
    int mode = 0;
    int m_err = 0;
    int m_code = 0;

    formula_loader dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_num(in_num), .in_val(in_val), .in_eoc(in_eoc), .in_eof(in_eof),
        .out_formula(out_formula), .out_valid(out_valid), .out_ready(out_ready),
        .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", name, got, exp);
        end
    endtask

    task automatic chkf(input string name, input common::formula got, input common::formula exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    function automatic common::formula model_f();
        common::formula f = '0;
        for (int c = 0; c < NC; c++)
            if (cls[c].size() > 0) begin
                f.clauses[c].len = LW'(cls[c].size());
                for (int l = 0; l < cls[c].size(); l++) begin
                    f.clauses[c].lits[l].num = LW'(cls[c][l] / 2);
                    f.clauses[c].lits[l].val = 1'(cls[c][l] % 2);
                end
                f.len = CW'(c + 1);
            end
        return f;
    endfunction

    function automatic void clear_model();
        foreach (cls[c]) cls[c].delete();
        nclosed = 0;
    endfunction

    function automatic void model_step();
        int code, open_sz;
        bit acc;
        acc = in_valid && mode != 1;
        open_sz = nclosed < NC ? cls[nclosed].size() : 0;
        code = (in_num == 0 || int'(in_num) > NL) ? 1 : open_sz == NL ? 2 : nclosed == NC ? 3 : 0;
        if (mode == 0) begin
            m_err = 0;
            m_code = 0;
            if (acc && code != 0) begin
                m_err = 1;
                m_code = code;
                if (in_eof) clear_model();
                else mode = 2;
            end else if (acc) begin
                cls[nclosed].push_back(int'(in_num) * 2 + int'(in_val));
                if (in_eoc || in_eof) nclosed++;
                if (in_eof) mode = 1;
            end
        end else if (mode == 1) begin
            m_err = 0;
            m_code = 0;
            if (out_ready) begin
                clear_model();
                mode = 0;
            end
        end else if (acc && in_eof) begin
            clear_model();
            mode = 0;
            m_err = 0;
            m_code = 0;
        end
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            clear_model();
            mode = 0;
            m_err = 0;
            m_code = 0;
        end else begin
            model_step();
        end
        #1;
        chk("in_ready", int'(in_ready), int'(mode != 1));
        chk("out_valid", int'(out_valid), int'(mode == 1));
        chk("err", int'(err), m_err);
        chk("err_code", int'(err_code), m_code);
        chkf("formula", out_formula, model_f());
    end

    task automatic send(input int n, input bit v, input bit c, input bit f);
        @(negedge clk);
        in_valid = 1'b1;
        in_num = LW'(n);
        in_val = v;
        in_eoc = c;
        in_eof = f;
        for (int i = 0; i < 50 && !in_ready; i++) @(negedge clk);
        if (!in_ready) chk("send_timeout", 0, 1);
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        in_eoc = 1'b0;
        in_eof = 1'b0;
    endtask

    task automatic release_formula();
        idle();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    common::formula exp_f;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        chk("reset_in_ready", int'(in_ready), 1);
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_err", int'(err), 0);
        chkf("reset_formula", out_formula, '0);
        @(negedge clk);
        rst = 1'b0;

        send(1, 1, 0, 0);
        send(2, 0, 1, 0);
        send(3, 1, 0, 1);
        #1;
        chk("basic_out_valid", int'(out_valid), 1);
        chk("basic_in_ready", int'(in_ready), 0);
        exp_f = '0;
        exp_f.len = 2;
        exp_f.clauses[0].len = 2;
        exp_f.clauses[0].lits[0] = {3'd1, 1'b1};
        exp_f.clauses[0].lits[1] = {3'd2, 1'b0};
        exp_f.clauses[1].len = 1;
        exp_f.clauses[1].lits[0] = {3'd3, 1'b1};
        chkf("basic_formula", out_formula, exp_f);

        @(negedge clk);
        in_valid = 1'b1;
        in_num = 3'd4;
        in_val = 1'b1;
        in_eoc = 1'b0;
        in_eof = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp_in_ready", int'(in_ready), 0);
            chkf("bp_formula", out_formula, exp_f);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_valid", int'(out_valid), 0);
        chkf("bp_release_clear", out_formula, '0);
        @(negedge clk);
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        chk("bp_next_len", int'(out_formula.len), 1);
        chk("bp_next_lit", int'(out_formula.clauses[0].lits[0]), 9);
        release_formula();

        for (int c = 0; c < NC; c++)
            for (int l = 0; l < NL; l++)
                send(l + 1, 1'((c * NL + l) % 2), l == NL - 1, c == NC - 1 && l == NL - 1);
        #1;
        chk("full_err", int'(err), 0);
        chk("full_len", int'(out_formula.len), 10);
        chk("full_clause9_len", int'(out_formula.clauses[9].len), 5);
        chk("full_last_lit", int'(out_formula.clauses[9].lits[4]), 11);
        release_formula();

        for (int l = 1; l <= 5; l++) send(l, 1, 0, 0);
        send(1, 0, 0, 0);
        #1;
        chk("ovf_err", int'(err), 1);
        chk("ovf_code", int'(err_code), 2);
        for (int i = 0; i < 3; i++) send(2, 1, 0, 0);
        send(2, 0, 0, 1);
        #1;
        chk("drain_err", int'(err), 0);
        chk("drain_code", int'(err_code), 0);
        chkf("drain_formula", out_formula, '0);
        send(5, 0, 0, 1);
        #1;
        chk("recover_len", int'(out_formula.len), 1);
        chk("recover_lit", int'(out_formula.clauses[0].lits[0]), 10);
        release_formula();

        send(0, 1, 0, 0);
        #1;
        chk("num0_code", int'(err_code), 1);
        send(1, 1, 0, 1);
        send(6, 1, 0, 0);
        #1;
        chk("num6_code", int'(err_code), 1);
        send(1, 1, 0, 1);
        for (int c = 0; c < NC; c++) send(c % 5 + 1, 0, 1, 0);
        send(1, 1, 0, 0);
        #1;
        chk("clause11_code", int'(err_code), 3);
        send(1, 1, 0, 1);
        send(0, 1, 0, 1);
        #1;
        chk("pulse_err", int'(err), 1);
        chk("pulse_code", int'(err_code), 1);
        idle();
        @(posedge clk);
        #1;
        chk("pulse_fall", int'(err), 0);

        for (int l = 1; l <= 4; l++) send(l, 0, 0, 0);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_err", int'(err), 0);
        chkf("rst_formula", out_formula, '0);
        @(negedge clk);
        rst = 1'b0;
        send(3, 0, 0, 1);
        #1;
        chk("fresh_len", int'(out_formula.len), 1);
        chk("fresh_clause_len", int'(out_formula.clauses[0].len), 1);
        release_formula();
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/formula_loader.md
# formula_loader

Stream-to-structure front end for the SAT solver. Accepts a serial literal stream (one literal per beat, with end-of-clause and end-of-formula markers) over a valid/ready handshake and assembles the packed `formula` structure from the `common` package. Presents the completed formula to the solver core over a second valid/ready handshake. It is the writer of the formula structure that the solver's formula stack reads.

## Interface
- `NUM_CLAUSES`, default 10: clause capacity; equals `common::number_clauses`.
- `NUM_LITERALS`, default 5: literal capacity per clause and maximum variable index; equals `common::number_literal`.
- `LW`, derived as `$clog2(NUM_LITERALS+1)`: literal-number and clause-length width.
- `CW`, derived as `$clog2(NUM_CLAUSES+1)`: clause-count width.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  literal beat valid.
- `in_ready`  out  1  loader accepts a beat.
- `in_num`  in  LW  variable index; legal range is 1..NUM_LITERALS.
- `in_val`  in  1  polarity: 1 = positive literal, 0 = negated literal.
- `in_eoc`  in  1  this beat is the last literal of its clause.
- `in_eof`  in  1  this beat is the last literal of the formula; it implies `in_eoc`.
- `out_formula`  out  `common::formula`  assembled formula.
- `out_valid`  out  1  `out_formula` is complete and stable.
- `out_ready`  in  1  the solver takes the formula.
- `err`  out  1  a load error has occurred; the current formula is being discarded.
- `err_code`  out  2  error cause: 0 none, 1 bad literal number, 2 clause overflow, 3 formula overflow.

## Operation
- States are COLLECT, DONE and ERR. Internal counters are `lit_idx` (width LW) and `clause_idx` (width CW).
- A beat is accepted when `in_valid && in_ready`.
- `in_ready` is decoded from state only: it is 1 in COLLECT and ERR, and 0 in DONE. It never depends on `in_valid`.
- **COLLECT, on an accepted beat, checks errors in priority order:**
  - `in_num == 0` or `in_num > NUM_LITERALS` gives code 1.
  - `lit_idx == NUM_LITERALS` gives code 2.
  - `clause_idx == NUM_CLAUSES` gives code 3.
  - On any error, go to ERR and latch the code.
  - Exception: if the erroring beat itself has `in_eof`, go directly to COLLECT and clear the formula. In that case `err` pulses for one cycle with the code.
- **COLLECT, otherwise:**
  - Write `{in_num, in_val}` to `clauses[clause_idx].lits[lit_idx]`.
  - Set `clauses[clause_idx].len = lit_idx+1` and `formula.len = clause_idx+1`.
  - Increment `lit_idx`.
- If `in_eoc` or `in_eof` is set, increment `clause_idx` and clear `lit_idx` to 0.
- If `in_eof` is set, go to DONE.
- Duplicate or complementary literals are stored as given; no check is made.
- **DONE:**
  - `out_valid` = 1 and `out_formula` is held constant.
  - On `out_ready` (that cycle): return to COLLECT, clear the formula to all-zero, and clear both counters.
- **ERR:**
  - `err` = 1 and `err_code` is held.
  - Accepted beats are discarded until a beat with `in_eof`.
  - On that beat: go to COLLECT, clear the formula and counters, and set `err_code` to 0.
- Unused clause and literal slots always read as zero.

## Timing
- **Reset values:** state COLLECT, `in_ready` 1, `out_valid` 0, `out_formula` all-zero, `err` 0, `err_code` 0, counters 0.
- **Reset mid-load** discards the partial formula immediately (asynchronously).
- **Throughput:** one beat per cycle in COLLECT.
- **Latency:** for an eof beat accepted at edge N, `out_valid` is 1 and `in_ready` is 0 from edge N onward.
- **Release:** the `out_valid && out_ready` handshake at edge M gives `out_valid` 0 and `in_ready` 1 after M. The first beat of the next formula can be accepted at edge M+1.
- **Error timing:** `err` rises at the edge that accepts the offending beat and falls at the edge that accepts the draining eof beat.
- `out_formula` changes only in COLLECT. It is stable for the entire time `out_valid` is high.

## Test plan
- **Basic load.** After reset, send (1,1), (2,0,eoc), (3,1,eof).
  - Expect `out_valid` high one edge after the last beat.
  - Expect `len` = 2, clause0 `len` = 2 with lits {1,1},{2,0}, and clause1 `len` = 1 with lit {3,1}.
  - All other slots are zero.
- **Backpressure.** Hold `out_ready` = 0 for 5 cycles with `in_valid` = 1.
  - `in_ready` stays 0, no beat is accepted, and the formula is stable.
  - On `out_ready` = 1, the formula clears and the next stream loads correctly.
- **Full capacity.** Send 10 clauses of 5 literals (num 1..5, alternating val), with eof on the last beat.
  - Expect `len` = 10 and every clause `len` = 5.
  - The 50th beat is accepted without error.
- **Errors and recovery.**
  - A 6th literal without eoc gives `err` = 1, code 2.
  - Three further beats are discarded, then eof returns `err` to 0.
  - A following valid formula loads correctly.
- **Bad literal numbers.** `in_num` = 0 gives code 1. `in_num` = 6 gives code 1. An 11th clause gives code 3.
- **Reset mid-operation.** Assert `rst` after 4 beats.
  - All outputs return to their reset values immediately.
  - A fresh one-clause formula loads with `len` = 1.
